// File: rtl/arithmetic_encoder_pkg.sv
// Shared constants and types for the multi-symbol range encoder core.
package arithmetic_encoder_pkg;

  localparam int          EC_MIN_PROB   = 4;
  localparam int          EC_PROB_SHIFT = 6;
  localparam logic [15:0] RANGE_RESET   = 16'h8000;
  localparam int          CNT_RESET     = -9;

  typedef logic        [15:0] range_t;
  typedef logic signed [31:0] cnt_t;
  typedef logic        [3:0]  d_t;

endpackage

// File: rtl/arithmetic_encoder_min_prob_lut.sv
// Min-probability ROM: address {N, k} returns EC_MIN_PROB*(N-k), or 0 when k > N.
module arith_enc_min_prob_lut
  import arithmetic_encoder_pkg::*;
#(
  parameter int GENERAL_LUT_ADDR_WIDTH = 8,
  parameter int GENERAL_LUT_DATA_WIDTH = 16
) (
  input  logic [GENERAL_LUT_ADDR_WIDTH-1:0] i_addr,
  output logic [GENERAL_LUT_DATA_WIDTH-1:0] o_data
);

  logic [3:0] w_n;
  logic [3:0] w_k;

  assign w_n = i_addr[7:4];
  assign w_k = i_addr[3:0];

  always_comb begin
    o_data = '0;
    if (w_k <= w_n) begin
      o_data = GENERAL_LUT_DATA_WIDTH'(EC_MIN_PROB * (int'(w_n) - int'(w_k)));
    end
  end

endmodule

// File: rtl/arithmetic_encoder.sv
// One-symbol-per-clock range encoder step with inline renormalization.
// Optional registered carry output enabled by defining ARITH_ENC_CARRY_EN.
module arithmetic_encoder
  import arithmetic_encoder_pkg::*;
#(
  parameter int GENERAL_DATA_16        = 16,
  parameter int GENERAL_DATA_32        = 32,
  parameter int GENERAL_SYMBOL_WIDTH   = 4,
  parameter int GENERAL_LUT_ADDR_WIDTH = 8,
  parameter int GENERAL_LUT_DATA_WIDTH = 16,
  parameter int GENERAL_D_SIZE         = 4
) (
  input  logic                            general_clk,
  input  logic                            reset,
  input  logic [GENERAL_DATA_16-1:0]      general_fl,
  input  logic [GENERAL_DATA_16-1:0]      general_fh,
  input  logic [GENERAL_SYMBOL_WIDTH-1:0] general_symbol,
  input  logic [GENERAL_SYMBOL_WIDTH:0]   general_nsyms,
  output logic [GENERAL_DATA_16-1:0]      RANGE_OUTPUT,
  output logic [GENERAL_DATA_16-1:0]      LOW_OUTPUT,
  output logic [GENERAL_DATA_32-1:0]      CNT_OUTPUT
`ifdef ARITH_ENC_CARRY_EN
  ,
  output logic                            CARRY_OUTPUT
`endif
);

  range_t r_range;
  range_t r_low;
  cnt_t   r_cnt;

  logic [3:0]                        w_n;
  logic [3:0]                        w_s_m1;
  logic [7:0]                        w_q;
  logic [9:0]                        w_fl_sc;
  logic [9:0]                        w_fh_sc;
  logic [17:0]                       w_prod_fl;
  logic [17:0]                       w_prod_fh;
  logic [GENERAL_LUT_DATA_WIDTH-1:0] w_minp_lo;
  logic [GENERAL_LUT_DATA_WIDTH-1:0] w_minp_hi;
  logic [16:0]                       w_u;
  logic [16:0]                       w_v;
  logic [16:0]                       w_low_new;
  range_t                            w_rng_new;
  d_t                                w_d;
  range_t                            w_range_sh;
  range_t                            w_low_sh;

  assign w_n     = 4'(general_nsyms - 5'd1);
  assign w_s_m1  = general_symbol - 4'd1;
  assign w_q     = r_range[15:8];
  assign w_fl_sc = 10'(general_fl >> EC_PROB_SHIFT);
  assign w_fh_sc = 10'(general_fh >> EC_PROB_SHIFT);

  arith_enc_min_prob_lut #(
    .GENERAL_LUT_ADDR_WIDTH(GENERAL_LUT_ADDR_WIDTH),
    .GENERAL_LUT_DATA_WIDTH(GENERAL_LUT_DATA_WIDTH)
  ) u_lut_lo (
    .i_addr({w_n, w_s_m1}),
    .o_data(w_minp_lo)
  );

  arith_enc_min_prob_lut #(
    .GENERAL_LUT_ADDR_WIDTH(GENERAL_LUT_ADDR_WIDTH),
    .GENERAL_LUT_DATA_WIDTH(GENERAL_LUT_DATA_WIDTH)
  ) u_lut_hi (
    .i_addr({w_n, general_symbol}),
    .o_data(w_minp_hi)
  );

  assign w_prod_fl = 18'(w_q) * 18'(w_fl_sc);
  assign w_prod_fh = 18'(w_q) * 18'(w_fh_sc);
  assign w_u       = 17'(w_prod_fl >> 1) + 17'(w_minp_lo);
  assign w_v       = 17'(w_prod_fh >> 1) + 17'(w_minp_hi);

  // fl == 32768 marks the first symbol: only the top of the interval moves
  always_comb begin
    w_low_new = {1'b0, r_low};
    w_rng_new = 16'(17'(r_range) - w_v);
    if (!general_fl[15]) begin
      w_low_new = 17'({1'b0, r_low} + {1'b0, r_range} - w_u);
      w_rng_new = 16'(w_u - w_v);
    end
  end

  always_comb begin
    w_d = 4'd15;
    for (int i = 0; i < 16; i++) begin
      if (w_rng_new[i]) w_d = 4'(15 - i);
    end
  end

  assign w_range_sh = 16'(w_rng_new << w_d);
  assign w_low_sh   = 16'(w_low_new << w_d);

  always_ff @(posedge general_clk) begin
    if (reset) begin
      r_range <= RANGE_RESET;
      r_low   <= '0;
      r_cnt   <= cnt_t'(CNT_RESET);
    end else if (w_rng_new != '0) begin
      r_range <= w_range_sh;
      r_low   <= w_low_sh;
      r_cnt   <= r_cnt + cnt_t'({28'd0, w_d});
    end
  end

`ifdef ARITH_ENC_CARRY_EN
  logic r_carry;

  always_ff @(posedge general_clk) begin
    if (reset) begin
      r_carry <= 1'b0;
    end else if (w_rng_new != '0) begin
      r_carry <= w_low_new[16];
    end
  end

  assign CARRY_OUTPUT = r_carry;
`endif

  assign RANGE_OUTPUT = r_range;
  assign LOW_OUTPUT   = r_low;
  assign CNT_OUTPUT   = r_cnt;

endmodule

// File: tb/tb_arithmetic_encoder.sv
// Directed-vector and randomized model check of arithmetic_encoder.
module tb_arithmetic_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] fl;
  logic [15:0] fh;
  logic [3:0]  sym;
  logic [4:0]  nsyms;
  logic [15:0] range_o;
  logic [15:0] low_o;
  logic [31:0] cnt_o;
`ifdef ARITH_ENC_CARRY_EN
  logic        carry_o;
`endif

  int total = 0;
  int bad   = 0;

  arithmetic_encoder dut (
    .general_clk   (clk),
    .reset         (rst),
    .general_fl    (fl),
    .general_fh    (fh),
    .general_symbol(sym),
    .general_nsyms (nsyms),
    .RANGE_OUTPUT  (range_o),
    .LOW_OUTPUT    (low_o),
    .CNT_OUTPUT    (cnt_o)
`ifdef ARITH_ENC_CARRY_EN
    ,
    .CARRY_OUTPUT  (carry_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] fl;
    logic [15:0] fh;
    logic [3:0]  sym;
    logic [4:0]  nsyms;
    logic [15:0] exp_range;
    logic [15:0] exp_low;
    int          exp_cnt;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic [4:0] n);
    @(negedge clk);
    rst = r; fl = a; fh = b; sym = s; nsyms = n;
    @(posedge clk);
    #1;
  endtask

  // reference model state
  longint m_rng, m_low, m_cnt;

  function automatic longint minp(input int n, input int k);
    if (k > n) return 0;
    return 4 * (n - k);
  endfunction

  task automatic model_step(input int a, input int b, input int s, input int ns);
    longint q, u, v, rn, ln;
    int n, d;
    n  = ns - 1;
    q  = m_rng / 256;
    v  = ((q * (b / 64)) / 2) + minp(n, s);
    if (a < 32768) begin
      u  = ((q * (a / 64)) / 2) + minp(n, (s + 15) % 16);
      ln = (m_low + m_rng - u) % 131072;
      rn = u - v;
    end else begin
      ln = m_low;
      rn = m_rng - v;
    end
    if (rn <= 0) return;
    d = 0;
    while (rn * (longint'(1) << d) < 32768) d++;
    m_rng = rn * (longint'(1) << d);
    m_low = (ln * (longint'(1) << d)) % 65536;
    m_cnt = m_cnt + d;
  endtask

  initial begin
    rst = 1'b1; fl = '0; fh = '0; sym = '0; nsyms = 5'd2;

    //          rst  fl     fh     s  ns  range  low    cnt carry
    vecs[0] = '{1'b1, 16'd0,     16'd0,     4'd0, 5'd2,  16'h8000, 16'd0,     -9, 1'b0};
    vecs[1] = '{1'b0, 16'd9690,  16'd3202,  4'd3, 5'd10, 16'd51744, 16'd53536, -6, 1'b0};
    vecs[2] = '{1'b0, 16'd9690,  16'd3202,  4'd3, 5'd10, 16'd40820, 16'd32324, -4, 1'b1};
    vecs[3] = '{1'b1, 16'd9690,  16'd3202,  4'd3, 5'd10, 16'h8000, 16'd0,     -9, 1'b0};
    vecs[4] = '{1'b0, 16'd9690,  16'd3202,  4'd3, 5'd10, 16'd51744, 16'd53536, -6, 1'b0};
    vecs[5] = '{1'b1, 16'd0,     16'd0,     4'd0, 5'd2,  16'h8000, 16'd0,     -9, 1'b0};
    // r' = 32768 - (64*512 + 0) = 0: state must hold
    vecs[6] = '{1'b0, 16'd32768, 16'd32768, 4'd1, 5'd2,  16'h8000, 16'd0,     -9, 1'b0};
    vecs[7] = '{1'b0, 16'd32768, 16'd16384, 4'd0, 5'd2,  16'd65520, 16'd0,     -7, 1'b0};
    // q=255: r' = 65520 - 131 = 65389, d = 0
    vecs[8] = '{1'b0, 16'd32768, 16'd64,    4'd0, 5'd2,  16'd65389, 16'd0,     -7, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_range", range_o, 16'h8000);
    check("reset_low", low_o, 0);
    check("reset_cnt", cnt_o, 32'hFFFFFFF7);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].fh, vecs[i].sym, vecs[i].nsyms);
      check($sformatf("v%0d_range", i), range_o, vecs[i].exp_range);
      check($sformatf("v%0d_low", i), low_o, vecs[i].exp_low);
      check($sformatf("v%0d_cnt", i), $signed(cnt_o), vecs[i].exp_cnt);
`ifdef ARITH_ENC_CARRY_EN
      check($sformatf("v%0d_carry", i), carry_o, vecs[i].exp_carry);
`endif
    end

    // randomized legal CDF stream against the reference model
    drive(1'b1, 16'd0, 16'd0, 4'd0, 5'd2);
    m_rng = 32768; m_low = 0; m_cnt = -9;
    for (int c = 0; c < 3000; c++) begin
      int ns, n, s, a, b, x;
      ns = $urandom_range(16, 2);
      n  = ns - 1;
      s  = $urandom_range(n, 0);
      if (s == 0) begin
        a = 32768;
        b = $urandom_range(32767, 0);
      end else begin
        x = $urandom_range(511, 1);
        a = x * 64 + $urandom_range(63, 0);
        b = (s == n) ? 0 : $urandom_range(x - 1, 0) * 64 + $urandom_range(63, 0);
      end
      drive(1'b0, 16'(a), 16'(b), 4'(s), 5'(ns));
      model_step(a, b, s, ns);
      total++;
      if (range_o != 16'(m_rng) || low_o != 16'(m_low) || cnt_o != 32'(m_cnt)
          || range_o < 16'h8000) begin
        bad++;
        $display("FAIL rand%0d: got r=%0d l=%0d c=%0d expected r=%0d l=%0d c=%0d",
                 c, range_o, low_o, $signed(cnt_o), m_rng, m_low, m_cnt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
